arbiter_grant_buffer: RTL and testbench

Downstream stage of the three-input arbiter: captures the data word of whichever requester holds the grant each cycle, tags it with its source index, and queues it in a small FIFO. It presents the queued beats on a valid/ready output port and raises `full` back to the arbiter so that no grant is issued while no entry is free. Single clock domain, synchronous active-low reset.

---
 rtl/arbiter_grant_buffer.sv | 119 +++++++++++
 tb/tb_arbiter_grant_buffer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_grant_buffer.sv
// arbiter_grant_buffer
// Captures the word of the currently granted requester, tags it with its
// source index and queues it in a DEPTH-entry FIFO. The FIFO drains through
// a valid/ready port, and `full` tells the arbiter to stop granting.
//
// Optional build macro: ARBITER_GRANT_CHECK_EN
//   defined     - multi-hot grants write nothing, and `err` latches (until
//                 reset) on a multi-hot grant or on a grant while full.
//   not defined - multi-hot grants resolve to the lowest index, a grant while
//                 full is dropped silently, and `err` is tied to 0.
module arbiter_grant_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic [WIDTH-1:0]         input0,
    input  logic [WIDTH-1:0]         input1,
    input  logic [WIDTH-1:0]         input2,
    input  logic                     grant0,
    input  logic                     grant1,
    input  logic                     grant2,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         out_data,
    output logic [1:0]               out_src,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Each entry holds {src[1:0], data[WIDTH-1:0]}.
    logic [WIDTH+1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic             w_any;
    logic             w_wr;
    logic             w_rd;
    logic [WIDTH+1:0] w_entry;
    logic [WIDTH+1:0] w_head;

    // Pick the granted word; when several grants are high, the lowest index wins.
    always_comb begin
        w_any   = grant0 | grant1 | grant2;
        w_entry = '0;
        if (grant0)
            w_entry = {2'd0, input0};
        else if (grant1)
            w_entry = {2'd1, input1};
        else if (grant2)
            w_entry = {2'd2, input2};
    end

`ifdef ARBITER_GRANT_CHECK_EN
    logic w_multi;
    logic r_err;

    assign w_multi = (grant0 & grant1) | (grant0 & grant2) | (grant1 & grant2);
    assign w_wr    = w_any & ~w_multi & ~full;

    // Any protocol violation latches the error flag until reset.
    always_ff @(posedge clk) begin
        if (!res_n)
            r_err <= 1'b0;
        else if (w_multi | (w_any & full))
            r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign w_wr = w_any & ~full;
    assign err  = 1'b0;
`endif

    // full and out_valid come from the registered count only, so a write
    // cannot bypass to the output and a read cannot admit a write while full.
    assign full      = (r_count == CNT_FULL);
    assign out_valid = (r_count != '0);
    assign count     = r_count;
    assign w_rd      = out_valid & out_ready;
    assign w_head    = r_mem[r_rd_ptr];
    assign out_data  = out_valid ? w_head[WIDTH-1:0] : '0;
    assign out_src   = out_valid ? w_head[WIDTH+1:WIDTH] : 2'd0;

    // Store the accepted beat. The memory has no reset and is never read back
    // while empty.
    always_ff @(posedge clk) begin
        if (res_n && w_wr)
            r_mem[r_wr_ptr] <= w_entry;
    end

    // Pointers and occupancy. The pointers wrap naturally because DEPTH is a
    // power of two.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter_grant_buffer.sv
// Testbench for arbiter_grant_buffer. It uses a directed vector table,
// hand-written corner-case sequences and random traffic checked against a
// queue-based reference model.
module tb_arbiter_grant_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

`ifdef ARBITER_GRANT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic             clk;
    logic             res_n;
    logic [WIDTH-1:0] input0, input1, input2;
    logic             grant0, grant1, grant2;
    logic             full;
    logic [2:0]       count;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_src;
    logic             out_valid;
    logic             out_ready;
    logic             err;

    arbiter_grant_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .input0    (input0),
        .input1    (input1),
        .input2    (input2),
        .grant0    (grant0),
        .grant1    (grant1),
        .grant2    (grant2),
        .full      (full),
        .count     (count),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of {src, data} beats plus a sticky flag.
    typedef struct {
        logic [1:0]       src;
        logic [WIDTH-1:0] data;
    } ent_t;
    ent_t m_q[$];
    bit   m_err;

    function automatic void model_step(input bit rst_n, input logic [2:0] g,
                                       input logic [WIDTH-1:0] d0,
                                       input logic [WIDTH-1:0] d1,
                                       input logic [WIDTH-1:0] d2,
                                       input bit rdy);
        int   ng;
        bit   was_full;
        bit   do_wr;
        bit   do_rd;
        ent_t e;
        if (!rst_n) begin
            m_q.delete();
            m_err = 1'b0;
            return;
        end
        ng       = int'(g[0]) + int'(g[1]) + int'(g[2]);
        was_full = (m_q.size() == DEPTH);
        do_wr    = (ng > 0) && !was_full && !(CHK && ng > 1);
        do_rd    = (m_q.size() != 0) && rdy;
        if (CHK && (ng > 1 || (ng > 0 && was_full)))
            m_err = 1'b1;
        if (g[0])      begin e.src = 2'd0; e.data = d0; end
        else if (g[1]) begin e.src = 2'd1; e.data = d1; end
        else           begin e.src = 2'd2; e.data = d2; end
        if (do_rd) void'(m_q.pop_front());
        if (do_wr) m_q.push_back(e);
    endfunction

    task automatic check_model(input string tag);
        bit               v;
        logic [WIDTH-1:0] d;
        logic [1:0]       s;
        v = (m_q.size() != 0);
        d = v ? m_q[0].data : '0;
        s = v ? m_q[0].src  : 2'd0;
        check({tag, ".count"}, int'(count),     m_q.size());
        check({tag, ".valid"}, int'(out_valid), int'(v));
        check({tag, ".full"},  int'(full),      int'(m_q.size() == DEPTH));
        check({tag, ".data"},  int'(out_data),  int'(d));
        check({tag, ".src"},   int'(out_src),   int'(s));
        check({tag, ".err"},   int'(err),       int'(m_err));
    endtask

    // Apply one cycle of inputs, advance the model and sample #1 after the edge.
    task automatic cyc(input bit rst_n, input logic [2:0] g,
                       input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                       input logic [WIDTH-1:0] d2, input bit rdy);
        res_n = rst_n;
        {grant2, grant1, grant0} = g;
        input0 = d0; input1 = d1; input2 = d2;
        out_ready = rdy;
        @(posedge clk);
        #1;
        model_step(rst_n, g, d0, d1, d2, rdy);
        res_n = 1'b1;
        {grant2, grant1, grant0} = 3'b000;
        out_ready = 1'b0;
    endtask

    typedef struct {
        bit               rst_n;
        logic [2:0]       g;
        logic [WIDTH-1:0] d0, d1, d2;
        bit               rdy;
        int               e_count;
        bit               e_valid;
        logic [WIDTH-1:0] e_data;
        logic [1:0]       e_src;
        bit               e_full;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input bit r, input logic [2:0] g,
                                input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                                input logic [WIDTH-1:0] d2, input bit rdy,
                                input int c, input bit v, input logic [WIDTH-1:0] d,
                                input logic [1:0] s, input bit f);
        vec_t x;
        x.rst_n = r; x.g = g; x.d0 = d0; x.d1 = d1; x.d2 = d2; x.rdy = rdy;
        x.e_count = c; x.e_valid = v; x.e_data = d; x.e_src = s; x.e_full = f;
        return x;
    endfunction

    initial begin
        res_n = 1'b0; out_ready = 1'b0;
        {grant2, grant1, grant0} = 3'b000;
        input0 = '0; input1 = '0; input2 = '0;
        m_err = 1'b0;

        //            rst g      d0    d1    d2    rdy cnt v  data  src full
        vt.push_back(mk(0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        vt.push_back(mk(1, 3'b010, 8'h00, 8'h5A, 8'h00, 0, 1, 1, 8'h5A, 1, 0));
        vt.push_back(mk(0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        vt.push_back(mk(1, 3'b001, 8'h10, 8'h00, 8'h00, 0, 1, 1, 8'h10, 0, 0));
        vt.push_back(mk(1, 3'b010, 8'h00, 8'h11, 8'h00, 0, 2, 1, 8'h10, 0, 0));
        vt.push_back(mk(1, 3'b100, 8'h00, 8'h00, 8'h12, 0, 3, 1, 8'h10, 0, 0));
        vt.push_back(mk(1, 3'b001, 8'h13, 8'h00, 8'h00, 0, 4, 1, 8'h10, 0, 1));
        vt.push_back(mk(1, 3'b000, 8'h00, 8'h00, 8'h00, 0, 4, 1, 8'h10, 0, 1));
        vt.push_back(mk(1, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3, 1, 8'h11, 1, 0));
        vt.push_back(mk(1, 3'b000, 8'h00, 8'h00, 8'h00, 1, 2, 1, 8'h12, 2, 0));
        vt.push_back(mk(1, 3'b000, 8'h00, 8'h00, 8'h00, 1, 1, 1, 8'h13, 0, 0));
        vt.push_back(mk(1, 3'b000, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        vt.push_back(mk(1, 3'b000, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        vt.push_back(mk(1, 3'b100, 8'h00, 8'h00, 8'h77, 1, 1, 1, 8'h77, 2, 0));
        vt.push_back(mk(1, 3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 1, 8'h77, 2, 0));

        for (int i = 0; i < vt.size(); i++) begin
            cyc(vt[i].rst_n, vt[i].g, vt[i].d0, vt[i].d1, vt[i].d2, vt[i].rdy);
            check($sformatf("vec%0d.count", i), int'(count),     vt[i].e_count);
            check($sformatf("vec%0d.valid", i), int'(out_valid), int'(vt[i].e_valid));
            check($sformatf("vec%0d.data", i),  int'(out_data),  int'(vt[i].e_data));
            check($sformatf("vec%0d.src", i),   int'(out_src),   int'(vt[i].e_src));
            check($sformatf("vec%0d.full", i),  int'(full),      int'(vt[i].e_full));
            check($sformatf("vec%0d.err", i),   int'(err),       0);
        end

        // Grant while full with out_ready high: the grant is dropped and the read still happens.
        cyc(0, 3'b000, 8'h00, 8'h00, 8'h00, 0);
        cyc(1, 3'b001, 8'h20, 8'h00, 8'h00, 0);
        cyc(1, 3'b010, 8'h00, 8'h21, 8'h00, 0);
        cyc(1, 3'b100, 8'h00, 8'h00, 8'h22, 0);
        cyc(1, 3'b001, 8'h23, 8'h00, 8'h00, 0);
        cyc(1, 3'b100, 8'h00, 8'h00, 8'hEE, 1);
        check("fullgrant.count", int'(count),    3);
        check("fullgrant.data",  int'(out_data), 8'h21);
        check("fullgrant.err",   int'(err),      int'(CHK));
        for (int i = 0; i < 4; i++) begin
            cyc(1, 3'b000, 8'h00, 8'h00, 8'h00, 1);
            check_model($sformatf("fulldrain%0d", i));
        end

        // Hold steady state at count 2 with a grant and a read every cycle,
        // long enough for the pointers to wrap.
        cyc(0, 3'b000, 8'h00, 8'h00, 8'h00, 0);
        cyc(1, 3'b001, 8'h40, 8'h00, 8'h00, 0);
        cyc(1, 3'b010, 8'h00, 8'h41, 8'h00, 0);
        for (int i = 0; i < 10; i++) begin
            logic [2:0]       g;
            logic [WIDTH-1:0] d;
            g = 3'b001 << (i % 3);
            d = 8'(8'h42 + i);
            cyc(1, g, d, d, d, 1);
            check($sformatf("steady%0d.count", i), int'(count),    2);
            check($sformatf("steady%0d.data", i),  int'(out_data), int'(8'(8'h41 + i)));
            check_model($sformatf("steady%0d", i));
        end

        // Multi-hot grant.
        cyc(0, 3'b000, 8'h00, 8'h00, 8'h00, 0);
        cyc(1, 3'b101, 8'hAA, 8'h00, 8'hBB, 0);
        if (CHK) begin
            check("multihot.count", int'(count), 0);
            check("multihot.err",   int'(err),   1);
        end else begin
            check("multihot.count", int'(count),    1);
            check("multihot.data",  int'(out_data), 8'hAA);
            check("multihot.src",   int'(out_src),  0);
        end

        // Reset with count 3 and a grant active.
        cyc(1, 3'b010, 8'h00, 8'h51, 8'h00, 0);
        cyc(1, 3'b100, 8'h00, 8'h00, 8'h52, 0);
        if (!CHK) cyc(1, 3'b000, 8'h00, 8'h00, 8'h00, 0);
        else      cyc(1, 3'b001, 8'h53, 8'h00, 8'h00, 0);
        check("prereset.count", int'(count), 3);
        cyc(0, 3'b010, 8'h00, 8'h99, 8'h00, 1);
        check("reset.count", int'(count),     0);
        check("reset.valid", int'(out_valid), 0);
        check("reset.full",  int'(full),      0);
        check("reset.err",   int'(err),       0);
        check("reset.data",  int'(out_data),  0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int               r;
            logic [2:0]       g;
            bit               rst_n;
            bit               rdy;
            r = int'($urandom_range(0, 19));
            if (r < 3)       g = 3'b000;
            else if (r == 3) g = 3'b011 << $urandom_range(0, 1);
            else if (r == 4) g = 3'b111;
            else             g = 3'b001 << $urandom_range(0, 2);
            rst_n = ($urandom_range(0, 99) != 0);
            rdy   = ($urandom_range(0, 9) < 4);
            cyc(rst_n, g, 8'($urandom), 8'($urandom), 8'($urandom), rdy);
            check_model($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
